// File: rtl/flight_control_sequencer.sv
// -----------------------------------------------------------------------------
// flight_control_sequencer
//
// Front end of the flight model. It generates the periodic update strobe,
// collects pilot button presses over each update interval and turns them into
// signed angular-rate commands and a saturating throttle setting. It also runs
// the update_enable / update_done handshake with the plane state model and
// counts the interval boundaries that are dropped while an update is still
// outstanding.
//
// Ports:
//   clk            system clock (single domain)
//   reset          synchronous, active-high reset
//   pitch_up/down, roll_left/right, yaw_left/right, throttle_up/down
//                  synchronized, debounced pilot buttons
//   update_done    completion from the plane state model (only seen in WAIT)
//   update_enable  update request to the plane state model
//   pitch_change   signed deg/sec, + = nose up
//   roll_change    signed deg/sec, + = roll left
//   heading_change signed deg/sec, + = yaw right
//   throttle       0..THROTTLE_MAX percent
//   tick           one-cycle pulse on the last cycle of each interval
//   overrun_count  saturating count of dropped ticks
// -----------------------------------------------------------------------------
module flight_control_sequencer #(
  parameter int CLOCK_FREQUENCY  = 166000000,
  parameter int UPDATE_MS        = 100,
  parameter int ANGLE_WIDTH      = 16,
  parameter int PITCH_RATE       = 10,
  parameter int ROLL_RATE        = 15,
  parameter int HEADING_RATE     = 5,
  parameter int THROTTLE_STEP    = 5,
  parameter int THROTTLE_MAX     = 100,
  parameter int INITIAL_THROTTLE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pitch_up,
  input  logic                   pitch_down,
  input  logic                   roll_left,
  input  logic                   roll_right,
  input  logic                   yaw_left,
  input  logic                   yaw_right,
  input  logic                   throttle_up,
  input  logic                   throttle_down,
  input  logic                   update_done,
  output logic                   update_enable,
  output logic [ANGLE_WIDTH-1:0] pitch_change,
  output logic [ANGLE_WIDTH-1:0] roll_change,
  output logic [ANGLE_WIDTH-1:0] heading_change,
  output logic [7:0]             throttle,
  output logic                   tick,
  output logic [15:0]            overrun_count
);

  localparam int TICKS = CLOCK_FREQUENCY / 1000 * UPDATE_MS;
  localparam int CNT_W = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICKS - 1);

  localparam logic [ANGLE_WIDTH-1:0] PITCH_MAG   = ANGLE_WIDTH'(PITCH_RATE);
  localparam logic [ANGLE_WIDTH-1:0] ROLL_MAG    = ANGLE_WIDTH'(ROLL_RATE);
  localparam logic [ANGLE_WIDTH-1:0] HEADING_MAG = ANGLE_WIDTH'(HEADING_RATE);

  localparam logic [8:0] STEP9 = 9'(THROTTLE_STEP);
  localparam logic [8:0] MAX9  = 9'(THROTTLE_MAX);

  // Bit positions inside the packed button vector.
  localparam int B_PITCH_UP   = 0;
  localparam int B_PITCH_DOWN = 1;
  localparam int B_ROLL_LEFT  = 2;
  localparam int B_ROLL_RIGHT = 3;
  localparam int B_YAW_LEFT   = 4;
  localparam int B_YAW_RIGHT  = 5;
  localparam int B_THR_UP     = 6;
  localparam int B_THR_DOWN   = 7;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] interval_cnt;
  logic [7:0]       buttons;
  logic [7:0]       btn_latch;
  logic [7:0]       snap;
  logic [7:0]       throttle_next;
  logic [8:0]       throttle9;
  logic [8:0]       throttle_sum;

  assign buttons = {throttle_down, throttle_up, yaw_right, yaw_left,
                    roll_right, roll_left, pitch_down, pitch_up};

  // A press on the boundary cycle itself still belongs to the closing interval.
  assign snap = btn_latch | buttons;

  assign tick = (interval_cnt == LAST_COUNT);

  // Opposing buttons cancel; the negative rate is the two's complement of the
  // magnitude at the output width.
  function automatic logic [ANGLE_WIDTH-1:0] decode_rate(
    input logic                   pos,
    input logic                   neg,
    input logic [ANGLE_WIDTH-1:0] mag
  );
    if (pos && !neg) return mag;
    if (neg && !pos) return -mag;
    return '0;
  endfunction

  // Throttle arithmetic is done one bit wider so the add can exceed
  // THROTTLE_MAX before clamping instead of wrapping.
  assign throttle9    = {1'b0, throttle};
  assign throttle_sum = throttle9 + STEP9;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    throttle_next = throttle;
    if (snap[B_THR_UP] && !snap[B_THR_DOWN]) begin
      throttle_next = (throttle_sum > MAX9) ? MAX9[7:0] : throttle_sum[7:0];
    end else if (snap[B_THR_DOWN] && !snap[B_THR_UP]) begin
      throttle_next = (throttle9 < STEP9) ? 8'd0 : 8'(throttle9 - STEP9);
    end
  end

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      interval_cnt   <= '0;
      btn_latch      <= '0;
      update_enable  <= 1'b0;
      pitch_change   <= '0;
      roll_change    <= '0;
      heading_change <= '0;
      throttle       <= 8'(INITIAL_THROTTLE);
      overrun_count  <= '0;
    end else begin
      // Free-running interval counter, independent of the handshake.
      interval_cnt <= tick ? '0 : interval_cnt + 1'b1;

      // Latches keep collecting; only a taken snapshot clears them.
      btn_latch <= snap;

      case (state)
        ST_IDLE: begin
          if (tick) begin
            pitch_change   <= decode_rate(snap[B_PITCH_UP], snap[B_PITCH_DOWN], PITCH_MAG);
            roll_change    <= decode_rate(snap[B_ROLL_LEFT], snap[B_ROLL_RIGHT], ROLL_MAG);
            heading_change <= decode_rate(snap[B_YAW_RIGHT], snap[B_YAW_LEFT], HEADING_MAG);
            throttle       <= throttle_next;
            btn_latch      <= '0;
            update_enable  <= 1'b1;
            state          <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // A boundary while the model is still busy is dropped, even when
          // update_done arrives on the same cycle.
          if (tick && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
          end
          if (update_done) begin
            update_enable <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flight_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flight_control_sequencer
//
// Directed scenarios followed by a randomized stretch, all compared every cycle
// against an interval-level reference model: the model tracks the cycle index
// since reset, which buttons were seen during the current interval, whether an
// update is outstanding, and the resulting rates/throttle/overrun count.
// -----------------------------------------------------------------------------
module tb_flight_control_sequencer;

  localparam int TICKS = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  btn = '0;  // {thr_dn, thr_up, yaw_r, yaw_l, roll_r, roll_l, pitch_dn, pitch_up}
  logic        update_done = 1'b1;
  logic        update_enable;
  logic [15:0] pitch_change;
  logic [15:0] roll_change;
  logic [15:0] heading_change;
  logic [7:0]  throttle;
  logic        tick;
  logic [15:0] overrun_count;

  localparam logic [7:0] PU = 8'h01, PD = 8'h02, RL = 8'h04, RR = 8'h08;
  localparam logic [7:0] YL = 8'h10, YR = 8'h20, TU = 8'h40, TD = 8'h80;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  int         cyc;
  bit         m_wait;
  logic [7:0] m_press;
  int         m_pitch, m_roll, m_head, m_thr, m_ovr;

  flight_control_sequencer #(
    .CLOCK_FREQUENCY (10000),
    .UPDATE_MS       (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pitch_up       (btn[0]),
    .pitch_down     (btn[1]),
    .roll_left      (btn[2]),
    .roll_right     (btn[3]),
    .yaw_left       (btn[4]),
    .yaw_right      (btn[5]),
    .throttle_up    (btn[6]),
    .throttle_down  (btn[7]),
    .update_done    (update_done),
    .update_enable  (update_enable),
    .pitch_change   (pitch_change),
    .roll_change    (roll_change),
    .heading_change (heading_change),
    .throttle       (throttle),
    .tick           (tick),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rate(input bit pos, input bit neg, input int mag);
    if (pos && !neg) return mag;
    if (neg && !pos) return -mag;
    return 0;
  endfunction

  function automatic logic [31:0] as16(input int v);
    logic [15:0] t;
    t = 16'(v);
    return {16'h0, t};
  endfunction

  task automatic model_reset();
    cyc     = 0;
    m_wait  = 0;
    m_press = '0;
    m_pitch = 0;
    m_roll  = 0;
    m_head  = 0;
    m_thr   = 0;
    m_ovr   = 0;
  endtask

  // Advances the model across one clock edge using the inputs now applied.
  task automatic model_cycle();
    bit         boundary;
    logic [7:0] s;
    if (reset) begin
      model_reset();
      return;
    end
    boundary = (cyc % TICKS) == TICKS - 1;
    s = m_press | btn;
    if (!m_wait && boundary) begin
      m_pitch = rate(s[0], s[1], 10);
      m_roll  = rate(s[2], s[3], 15);
      m_head  = rate(s[5], s[4], 5);
      if (s[6] && !s[7]) m_thr = (m_thr + 5 > 100) ? 100 : m_thr + 5;
      else if (s[7] && !s[6]) m_thr = (m_thr < 5) ? 0 : m_thr - 5;
      m_press = '0;
      m_wait  = 1;
    end else begin
      m_press = s;
      if (m_wait) begin
        if (boundary && m_ovr < 65535) m_ovr++;
        if (update_done) m_wait = 0;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check("update_enable", {31'b0, update_enable}, {31'b0, m_wait});
    check("pitch_change", {16'h0, pitch_change}, as16(m_pitch));
    check("roll_change", {16'h0, roll_change}, as16(m_roll));
    check("heading_change", {16'h0, heading_change}, as16(m_head));
    check("throttle", {24'h0, throttle}, 32'(m_thr));
    check("overrun_count", {16'h0, overrun_count}, 32'(m_ovr));
  endtask

  // One clock cycle: check the combinational tick, step the model, cross the
  // edge, then check every registered output.
  task automatic step();
    logic exp_tick;
    exp_tick = ((cyc % TICKS) == TICKS - 1);
    check("tick", {31'b0, tick}, {31'b0, exp_tick});
    model_cycle();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_until_phase(input int ph);
    for (int i = 0; i < TICKS && (cyc % TICKS) != ph; i++) step();
  endtask

  initial begin
    // Reset and check the reset state.
    reset = 1'b1;
    update_done = 1'b1;
    btn = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_update_enable", {31'b0, update_enable}, 32'd0);
    check("rst_tick", {31'b0, tick}, 32'd0);
    check("rst_pitch", {16'h0, pitch_change}, 32'd0);
    check("rst_throttle", {24'h0, throttle}, 32'd0);
    check("rst_overrun", {16'h0, overrun_count}, 32'd0);
    reset = 1'b0;

    // Idle with update_done tied high: ticks at 9, 19, 29.
    for (int i = 0; i < 30; i++) step();

    // pitch_up one-cycle pulse at phase 3, both roll buttons held.
    run_until_phase(3);
    btn = PU | RL | RR;
    step();
    btn = RL | RR;
    run_until_phase(9);
    step();
    check("pitch_pulse", {16'h0, pitch_change}, 32'h000A);
    check("roll_both", {16'h0, roll_change}, 32'h0000);
    btn = '0;
    for (int i = 0; i < TICKS; i++) step();
    check("pitch_released", {16'h0, pitch_change}, 32'h0000);

    // Throttle ramps up to the ceiling, then back down to the floor.
    btn = YL | TU;
    for (int i = 0; i < 25 * TICKS; i++) step();
    check("heading_yaw_left", {16'h0, heading_change}, 32'h0000FFFB);
    check("throttle_ceiling", {24'h0, throttle}, 32'd100);
    btn = TD;
    for (int i = 0; i < 25 * TICKS; i++) step();
    check("throttle_floor", {24'h0, throttle}, 32'd0);

    // Stall: update_done low over three boundaries, pitch_down pressed inside.
    btn = '0;
    run_until_phase(9);
    update_done = 1'b0;
    for (int i = 0; i < 15; i++) step();
    btn = PD;
    step();
    btn = '0;
    for (int i = 0; i < 20; i++) step();
    check("stall_overrun", {16'h0, overrun_count}, 32'd3);
    check("stall_enable_held", {31'b0, update_enable}, 32'd1);
    check("stall_pitch_frozen", {16'h0, pitch_change}, 32'h0000);
    update_done = 1'b1;
    run_until_phase(9);
    step();
    check("stall_press_kept", {16'h0, pitch_change}, 32'h0000FFF6);

    // update_done coincident with a tick while in WAIT.
    update_done = 1'b0;
    run_until_phase(9);
    update_done = 1'b1;
    step();
    check("coincident_overrun", {16'h0, overrun_count}, 32'd4);
    check("coincident_enable_drop", {31'b0, update_enable}, 32'd0);
    run_until_phase(9);
    step();
    check("coincident_reissue", {31'b0, update_enable}, 32'd1);

    // Randomized buttons and handshake timing.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 8; b++) btn[b] = ($urandom_range(0, 99) < 10);
      update_done = ($urandom_range(0, 3) != 0);
      step();
    end

    // Bring throttle to 40, then reset in the middle of an update.
    update_done = 1'b1;
    btn = TD;
    for (int i = 0; i < 25 * TICKS; i++) step();
    run_until_phase(0);
    btn = TU;
    for (int i = 0; i < 8 * TICKS; i++) step();
    check("throttle_40", {24'h0, throttle}, 32'd40);
    btn = '0;
    update_done = 1'b0;
    step();
    check("pre_reset_waiting", {31'b0, update_enable}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("wait_reset_enable", {31'b0, update_enable}, 32'd0);
    check("wait_reset_throttle", {24'h0, throttle}, 32'd0);
    check("wait_reset_overrun", {16'h0, overrun_count}, 32'd0);
    update_done = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("tick_after_reset", {31'b0, tick}, 32'd1);
    for (int i = 0; i < 11; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
